// File: rtl/twiddle_gen.sv
// Twiddle-factor generator for one radix-2 SDF DIF FFT stage.
// Quarter-wave cosine ROM plus symmetry; W = exp(-j2*pi*k/N) in Q1.16, 2-cycle latency.
module twiddle_gen #(
   parameter int LOG2N = 8,
   parameter int STAGE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sync,
   output logic [16:0]      WR,
   output logic [16:0]      WI,
   output logic             w_valid,
   output logic             w_last,
   output logic [LOG2N-2:0] k_out
);
   localparam int N  = 1 << LOG2N;
   localparam int Q  = N / 4;
   localparam int L  = N >> STAGE;
   localparam int KW = LOG2N - 1;
   localparam real PI = 3.14159265358979323846;
   localparam logic [LOG2N-1:0] LMASK = LOG2N'(L - 1);
   localparam logic [LOG2N-1:0] HALF  = LOG2N'(L / 2);
   localparam logic [LOG2N-1:0] HALFN = LOG2N'(N / 2);
   localparam logic [LOG2N-1:0] NLAST = LOG2N'(N - 1);
   localparam logic [KW-1:0]    QK    = KW'(Q);

   typedef logic [Q:0][15:0] rom_t;

   // cos(0) rounds to 65536, which does not fit 16 bits; clamp to 65535.
   function automatic rom_t rom_init();
      rom_t r;
      real  v;
      int   c;
      r = '0;
      for (int i = 0; i <= Q; i++) begin
         v = $cos(2.0 * PI * real'(i) / real'(N)) * 65536.0;
         c = $rtoi(v + 0.5);
         if (c > 65535) c = 65535;
         if (c < 0) c = 0;
         r[i[KW-1:0]] = c[15:0];
      end
      return r;
   endfunction

   localparam rom_t ROM = rom_init();

   logic [LOG2N-1:0] n, cur, p, kf;
   logic [KW-1:0]    k, addr_r, addr_i;
   logic             neg_r, last;

   logic [1:0]       vld_pipe;
   logic [KW-1:0]    k_s1, ar_s1, ai_s1;
   logic             neg_s1, last_s1;

   always_comb begin
      cur    = in_sync ? '0 : n;
      p      = cur & LMASK;
      kf     = '0;
      if (p >= HALF) kf = (p - HALF) << STAGE;
      k      = kf[KW-1:0];
      addr_r = k;
      addr_i = QK - k;
      neg_r  = 1'b0;
      // Second quadrant: fold onto the first via cos(pi - x) = -cos(x).
      if (k > QK) begin
         addr_r = KW'(HALFN - kf);
         addr_i = k - QK;
         neg_r  = 1'b1;
      end
      last   = (cur == NLAST);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n        <= '0;
         vld_pipe <= '0;
         k_s1     <= '0;
         ar_s1    <= '0;
         ai_s1    <= '0;
         neg_s1   <= 1'b0;
         last_s1  <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[0], in_valid};
         if (in_valid) begin
            n       <= cur + LOG2N'(1);
            k_s1    <= k;
            ar_s1   <= addr_r;
            ai_s1   <= addr_i;
            neg_s1  <= neg_r;
            last_s1 <= last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         WR     <= '0;
         WI     <= '0;
         k_out  <= '0;
         w_last <= 1'b0;
      end else begin
         w_last <= vld_pipe[0] & last_s1;
         if (vld_pipe[0]) begin
            WR    <= neg_s1 ? -{1'b0, ROM[ar_s1]} : {1'b0, ROM[ar_s1]};
            WI    <= -{1'b0, ROM[ai_s1]};
            k_out <= k_s1;
         end
      end
   end

   assign w_valid = vld_pipe[1];
endmodule

// File: tb/tb_twiddle_gen.sv
// Directed bench for twiddle_gen: three configurations share one input stream.
module tb_twiddle_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_sync = 1'b0;

   logic [16:0] wr40, wi40, wr42, wi42, wr80, wi80;
   logic        wv40, wv42, wv80, wl40, wl42, wl80;
   logic [2:0]  k40, k42;
   logic [6:0]  k80;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   localparam real PI = 3.14159265358979323846;

   int kt40[16] = '{0,0,0,0,0,0,0,0,0,1,2,3,4,5,6,7};
   int kt42[16] = '{0,0,0,4,0,0,0,4,0,0,0,4,0,0,0,4};
   int wrt[8]   = '{65535,60547,46341,25080,0,-25080,-46341,-60547};
   int wit[8]   = '{0,-25080,-46341,-60547,-65535,-60547,-46341,-25080};
   int pg[8]    = '{1,0,1,1,0,1,0,0};
   int kg[8]    = '{0,0,0,0,0,4,4,4};
   int kr[4]    = '{0,0,0,4};

   twiddle_gen #(.LOG2N(4), .STAGE(0)) u40 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
      .WR(wr40), .WI(wi40), .w_valid(wv40), .w_last(wl40), .k_out(k40));
   twiddle_gen #(.LOG2N(4), .STAGE(2)) u42 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
      .WR(wr42), .WI(wi42), .w_valid(wv42), .w_last(wl42), .k_out(k42));
   twiddle_gen #(.LOG2N(8), .STAGE(0)) u80 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
      .WR(wr80), .WI(wi80), .w_valid(wv80), .w_last(wl80), .k_out(k80));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read on the next falling edge.
   task automatic tick(input logic v, input logic s);
      in_valid = v;
      in_sync  = s;
      @(negedge clk);
   endtask

   function automatic int qz(input real v);
      int c;
      if (v >= 0.0) begin
         c = $rtoi(v * 65536.0 + 0.5);
         if (c > 65535) c = 65535;
         return c;
      end
      c = $rtoi(-v * 65536.0 + 0.5);
      if (c > 65535) c = 65535;
      return -c;
   endfunction

   initial begin
      int  j, nexp, ke;
      real th;

      repeat (2) @(negedge clk);
      chk("rst_wr", $signed(wr40), 0);
      chk("rst_wi", $signed(wi40), 0);
      chk("rst_vld", wv40, 0);
      chk("rst_last", wl40, 0);
      chk("rst_k", k40, 0);
      rst = 1'b1;
      @(negedge clk);

      // One full N=16 frame starting with sync.
      for (int i = 0; i <= 16; i++) begin
         tick(i < 16, i == 0);
         if (i == 0) chk("a_lat", wv40, 0);
         else begin
            j = i - 1;
            chk($sformatf("a_vld[%0d]", j), wv40, 1);
            chk($sformatf("a_k40[%0d]", j), k40, kt40[j]);
            chk($sformatf("a_wr40[%0d]", j), $signed(wr40), wrt[kt40[j]]);
            chk($sformatf("a_wi40[%0d]", j), $signed(wi40), wit[kt40[j]]);
            chk($sformatf("a_wl40[%0d]", j), wl40, int'(j == 15));
            chk($sformatf("a_k42[%0d]", j), k42, kt42[j]);
            chk($sformatf("a_wr42[%0d]", j), $signed(wr42), wrt[kt42[j]]);
            chk($sformatf("a_wi42[%0d]", j), $signed(wi42), wit[kt42[j]]);
            chk($sformatf("a_wl42[%0d]", j), wl42, int'(j == 15));
         end
      end
      tick(0, 0);
      chk("a_tail_vld", wv40, 0);
      chk("a_tail_last", wl40, 0);

      // Gapped input; idle cycles must neither advance n nor move k_out.
      for (int i = 0; i <= 8; i++) begin
         tick(i < 8 ? pg[i][0] : 1'b0, 1'b0);
         if (i > 0) begin
            j = i - 1;
            chk($sformatf("b_vld[%0d]", j), wv42, pg[j]);
            chk($sformatf("b_k42[%0d]", j), k42, kg[j]);
         end
      end
      chk("b_wr42", $signed(wr42), 0);
      chk("b_wi42", $signed(wi42), -65535);

      // Resync at n=6; the sample carrying sync restarts the frame.
      for (int i = 0; i <= 18; i++) begin
         tick(i < 18, i == 2);
         if (i > 0) begin
            j    = i - 1;
            nexp = (j < 2) ? j + 4 : j - 2;
            ke   = (nexp >= 8) ? nexp - 8 : 0;
            chk($sformatf("c_k40[%0d]", j), k40, ke);
            chk($sformatf("c_wl40[%0d]", j), wl40, int'(nexp == 15));
         end
      end

      // Reset asserted mid-stream with in_valid high.
      for (int i = 0; i < 12; i++) tick(1, 0);
      chk("d_pre_k", k40, 2);
      chk("d_pre_wr", $signed(wr40), 46341);
      rst = 1'b0;
      #1;
      chk("d_rst_wr", $signed(wr40), 0);
      chk("d_rst_wi", $signed(wi40), 0);
      chk("d_rst_vld", wv40, 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i <= 5; i++) begin
         tick(i < 4, 1'b0);
         if (i == 0) chk("d_flush_vld", wv40, 0);
         else if (i <= 4) begin
            j = i - 1;
            chk($sformatf("d_vld[%0d]", j), wv42, 1);
            chk($sformatf("d_k42[%0d]", j), k42, kr[j]);
            if (j == 0) begin
               chk("d_k40", k40, 0);
               chk("d_wr40", $signed(wr40), 65535);
               chk("d_wi40", $signed(wi40), 0);
            end
         end
      end

      // Full N=256 frame against a floating-point cos/sin model.
      tick(0, 0);
      for (int i = 0; i <= 256; i++) begin
         tick(i < 256, i == 0);
         if (i > 0) begin
            j  = i - 1;
            ke = (j >= 128) ? j - 128 : 0;
            th = 2.0 * PI * real'(ke) / 256.0;
            chk($sformatf("e_k80[%0d]", j), k80, ke);
            chk($sformatf("e_wr80[%0d]", j), $signed(wr80), qz($cos(th)));
            chk($sformatf("e_wi80[%0d]", j), $signed(wi80), qz(-$sin(th)));
            chk($sformatf("e_wl80[%0d]", j), wl80, int'(j == 255));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/twiddle_gen.md
Name: twiddle_gen

Overview:
- Generates the twiddle-factor stream (WR, WI) consumed by the complex twiddle multiplier in one radix-2 single-path delay-feedback (SDF) DIF FFT stage.
- Counts the samples entering the stage and derives the exponent k from the sample position and the stage index.
- Reads a quarter-wave cosine ROM and applies symmetry to produce W = exp(-j2πk/N) in signed Q1.16, delivered with a fixed 2-cycle latency.

Parameters:
- LOG2N, 8, log2 of FFT length N (N = 2^LOG2N, N >= 8).
- STAGE, 0, index s of the FFT stage served (0 .. LOG2N-1); sets block length L = N >> s.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  one sample enters the stage this cycle.
- in_sync  input  1  qualified by in_valid; marks sample n = 0 of a frame.
- WR  output  17  signed Q1.16 real part of W.
- WI  output  17  signed Q1.16 imaginary part of W.
- w_valid  output  1  WR/WI valid for the sample accepted 2 cycles earlier.
- w_last  output  1  with w_valid; twiddle for sample n = N-1.
- k_out  output  LOG2N-1  exponent k matching WR/WI (debug/verification).

Behaviour:
- Reset (rst low, async): WR=0, WI=0, w_valid=0, w_last=0, k_out=0, sample counter n=0, all pipeline valids cleared. A reset mid-frame discards in-flight samples; the next accepted sample is n=0.
- Counter n (LOG2N bits):
  - On in_valid & in_sync: the sample is n=0 and the counter loads 1. This applies at any point, including mid-frame.
  - On in_valid alone: the sample is the current n; n increments, wrapping N-1 -> 0.
  - No in_valid: counter holds.
  - in_sync without in_valid is ignored.
- Exponent: p = n mod L.
  - p < L/2: k = 0 (upper-branch bypass, W = 1).
  - p >= L/2: k = (p - L/2) << STAGE.
  - Result: k ranges over 0 .. N/2-1.
- ROM: C[i] = round(cos(2πi/N) * 65536) for i = 0..N/4 (N/4+1 entries), saturated to 65535, so C[0] = 65535. Contents are computed at elaboration; no runtime writes.
- Symmetry mapping, Q = N/4:
  - k <= Q: WR = C[k], WI = -C[Q-k].
  - k > Q: WR = -C[N/2-k], WI = -C[k-Q].
  - WI <= 0 always. Negation never overflows because |C| <= 65535.
- Pipeline, fixed latency 2, no backpressure:
  - Cycle 0: sample accepted; k and the ROM address are computed and registered together with the negate flags, the valid and the last flag.
  - Cycle 1: ROM data is registered, negations are applied, and WR/WI/k_out/w_valid/w_last update.
  - Back-to-back in_valid gives one output per cycle. Gaps in in_valid propagate as gaps in w_valid.
- When w_valid=0, WR/WI/k_out hold their last values.
- w_last = 1 exactly with the output for n = N-1 and 0 otherwise. After N valid samples without sync, the counter wraps and frames continue.

Test Plan:
- Reset checks: assert rst low mid-stream with in_valid high -> WR=0, WI=0, w_valid=0 immediately; after release, the first accepted sample (no sync) yields k_out=0, WR=65535, WI=0.
- LOG2N=4, STAGE=0, 16 consecutive valids starting with in_sync:
  - n=0..8 -> k=0, WR=65535, WI=0.
  - n=10 -> k=2, WR=46341, WI=-46341.
  - n=12 -> k=4, WR=0, WI=-65535.
  - n=15 -> k=7, WR=-60547, WI=-25080, w_last=1.
  - Each output appears exactly 2 cycles after its input.
- LOG2N=4, STAGE=2 (L=4), continuous stream:
  - n=0,1 -> k=0; n=2 -> k=0; n=3 -> k=4 (WR=0, WI=-65535).
  - The pattern repeats every 4 samples; w_last only at n=15.
- Gapped input: in_valid pattern 1,0,1,1,0,1 -> w_valid pattern identical, delayed 2 cycles; counter does not advance on idle cycles.
- Resync: in_sync at n=6 -> that sample is treated as n=0 (k=0); the following sample is n=1, and w_last occurs 15 samples later.
- Full sweep: LOG2N=8, STAGE=0, one frame compared against a real-valued model round(cos/sin * 65536) with saturation -> exact match for all 256 samples.
